// File: rtl/mul_pkg.sv
// Shared definitions for the iterative multiply unit:
// op encodings, op-class helpers and the sequencer state type.
package mul_pkg;

    localparam logic [2:0] MUL_OP_MUL   = 3'd0;
    localparam logic [2:0] MUL_OP_MLA   = 3'd1;
    localparam logic [2:0] MUL_OP_UMULL = 3'd2;
    localparam logic [2:0] MUL_OP_UMLAL = 3'd3;
    localparam logic [2:0] MUL_OP_SMULL = 3'd4;
    localparam logic [2:0] MUL_OP_SMLAL = 3'd5;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_e;

    function automatic logic is_long(input logic [2:0] op);
        return (op == MUL_OP_UMULL) || (op == MUL_OP_UMLAL) ||
               (op == MUL_OP_SMULL) || (op == MUL_OP_SMLAL);
    endfunction

    function automatic logic is_signed(input logic [2:0] op);
        return (op == MUL_OP_SMULL) || (op == MUL_OP_SMLAL);
    endfunction

    function automatic logic is_acc(input logic [2:0] op);
        return (op == MUL_OP_MLA) || (op == MUL_OP_UMLAL) ||
               (op == MUL_OP_SMLAL);
    endfunction

    function automatic logic is_rsvd(input logic [2:0] op);
        return op[2] & op[1];
    endfunction

endpackage

// File: rtl/mul_step.sv
// One shift-add step: adds mcand * bits, shifted to bit
// position pos, into the double-width accumulator.
module mul_step #(
    parameter int WIDTH = 32,
    parameter int BPC   = 1,
    parameter int PW    = $clog2(WIDTH)
) (
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   mcand_i,
    input  logic [BPC-1:0]     bits_i,
    input  logic [PW-1:0]      pos_i,
    output logic [2*WIDTH-1:0] acc_next_o
);

    localparam int DW = 2 * WIDTH;

    logic [DW-1:0] pp;

    assign pp         = (DW'(mcand_i) * DW'(bits_i)) << pos_i;
    assign acc_next_o = acc_i + pp;

endmodule

// File: rtl/mul_unit_iter.sv
// Iterative MUL/MLA/xMULL/xMLAL engine: magnitude shift-add,
// then a single sign-fix and accumulate cycle before DONE.
module mul_unit_iter
    import mul_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int BPC   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] acc_lo,
    input  logic [WIDTH-1:0] acc_hi,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             flag_n,
    output logic             flag_z
);

    localparam int K  = WIDTH / BPC;
    localparam int PW = $clog2(WIDTH);
    localparam int CW = $clog2(K + 1);
    localparam int DW = 2 * WIDTH;

    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic [PW-1:0]    pos_q;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [2:0]       op_q;
    logic             neg_q;
    logic [DW-1:0]    addend_q;
    logic [DW-1:0]    acc_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] res_lo_q;
    logic [WIDTH-1:0] res_hi_q;
    logic             n_q;
    logic             z_q;

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [DW-1:0]    addend_d;
    logic [DW-1:0]    acc_step;
    logic [DW-1:0]    fix_sum;
    logic [WIDTH-1:0] res_lo_d;
    logic [WIDTH-1:0] res_hi_d;
    logic             n_d;
    logic             z_d;

    assign a_neg = is_signed(op) & a[WIDTH-1];
    assign b_neg = is_signed(op) & b[WIDTH-1];
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;

    always_comb begin
        addend_d = '0;
        if (is_acc(op)) begin
            if (is_long(op)) addend_d = {acc_hi, acc_lo};
            else             addend_d = {{WIDTH{1'b0}}, acc_lo};
        end
    end

    mul_step #(
        .WIDTH (WIDTH),
        .BPC   (BPC),
        .PW    (PW)
    ) u_step (
        .acc_i      (acc_q),
        .mcand_i    (mcand_q),
        .bits_i     (mplier_q[BPC-1:0]),
        .pos_i      (pos_q),
        .acc_next_o (acc_step)
    );

    always_comb begin
        fix_sum  = (neg_q ? -acc_q : acc_q) + addend_q;
        res_lo_d = fix_sum[WIDTH-1:0];
        res_hi_d = is_long(op_q) ? fix_sum[DW-1:WIDTH] : '0;
        if (is_rsvd(op_q)) begin
            res_lo_d = '0;
            res_hi_d = '0;
        end
        n_d = is_long(op_q) ? res_hi_d[WIDTH-1] : res_lo_d[WIDTH-1];
        z_d = ({res_hi_d, res_lo_d} == '0);
    end

    // Counter walks K..1 while stepping; the zero cycle hands over to FIX.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            pos_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            addend_q <= '0;
            acc_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            res_lo_q <= '0;
            res_hi_q <= '0;
            n_q      <= 1'b0;
            z_q      <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                    if (start) begin
                        mcand_q  <= a_mag;
                        mplier_q <= b_mag;
                        op_q     <= op;
                        neg_q    <= a_neg ^ b_neg;
                        addend_q <= addend_d;
                        acc_q    <= '0;
                        cnt_q    <= CW'(K);
                        pos_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= CALC;
                    end
                end
                CALC: begin
                    if (cnt_q == '0) begin
                        state_q <= FIX;
                    end else begin
                        acc_q    <= acc_step;
                        mplier_q <= mplier_q >> BPC;
                        pos_q    <= pos_q + PW'(BPC);
                        cnt_q    <= cnt_q - CW'(1);
                    end
                end
                FIX: begin
                    res_lo_q <= res_lo_d;
                    res_hi_q <= res_hi_d;
                    n_q      <= n_d;
                    z_q      <= z_d;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                    state_q  <= DONE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign result_lo = res_lo_q;
    assign result_hi = res_hi_q;
    assign flag_n    = n_q;
    assign flag_z    = z_q;

endmodule

// File: tb/tb_mul_unit_iter.sv
// Scoreboard bench for mul_unit_iter: main 32/1 instance plus
// 32/2, 32/4, 32/8 and 16/4 instances sharing operand inputs.
module tb_mul_unit_iter;

    typedef struct packed {
        logic [31:0] lo;
        logic [31:0] hi;
        logic        n;
        logic        z;
    } exp_t;

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] al;
        logic [31:0] ah;
    } vec_t;

    localparam vec_t VECS [5] = '{
        '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0},
        '{3'd4, 32'hFFFF_FFFE, 32'h0000_0003, 32'h0, 32'h0},
        '{3'd4, 32'h8000_0000, 32'h8000_0000, 32'h0, 32'h0},
        '{3'd1, 32'h0000_0007, 32'h0000_0006, 32'hFFFF_FFD6, 32'h0},
        '{3'd3, 32'h0000_0002, 32'h0000_0003, 32'hFFFF_FFFF, 32'h1}
    };

    localparam int CWID [4] = '{32, 32, 32, 16};
    localparam int CLAT [4] = '{18, 10, 6, 6};

    logic        clk = 1'b0;
    logic        rst;
    logic        start0;
    logic        startc;
    logic [2:0]  op;
    logic [31:0] a, b, al, ah;

    logic        busy0, done0, n0, z0;
    logic [31:0] lo0, hi0;

    logic        c_busy [4];
    logic        c_done [4];
    logic        c_n    [4];
    logic        c_z    [4];
    logic [31:0] c_lo   [4];
    logic [31:0] c_hi   [4];
    logic [15:0] lo16, hi16;

    int vectors = 0;
    int miscompares = 0;
    exp_t sb [$];

    always #5 clk = ~clk;

    mul_unit_iter #(.WIDTH(32), .BPC(1)) u0 (
        .clk(clk), .reset(rst), .start(start0), .op(op),
        .a(a), .b(b), .acc_lo(al), .acc_hi(ah),
        .busy(busy0), .done(done0),
        .result_lo(lo0), .result_hi(hi0),
        .flag_n(n0), .flag_z(z0)
    );

    for (genvar g = 0; g < 3; g++) begin : g32
        mul_unit_iter #(.WIDTH(32), .BPC(2 << g)) u (
            .clk(clk), .reset(rst), .start(startc), .op(op),
            .a(a), .b(b), .acc_lo(al), .acc_hi(ah),
            .busy(c_busy[g]), .done(c_done[g]),
            .result_lo(c_lo[g]), .result_hi(c_hi[g]),
            .flag_n(c_n[g]), .flag_z(c_z[g])
        );
    end

    mul_unit_iter #(.WIDTH(16), .BPC(4)) u16 (
        .clk(clk), .reset(rst), .start(startc), .op(op),
        .a(a[15:0]), .b(b[15:0]), .acc_lo(al[15:0]), .acc_hi(ah[15:0]),
        .busy(c_busy[3]), .done(c_done[3]),
        .result_lo(lo16), .result_hi(hi16),
        .flag_n(c_n[3]), .flag_z(c_z[3])
    );

    assign c_lo[3] = {16'd0, lo16};
    assign c_hi[3] = {16'd0, hi16};

    // Reference: true signed/unsigned product, reduced modulo 2^(2w).
    function automatic exp_t model(input int w, input logic [2:0] o,
                                   input logic [31:0] x, y, l, h);
        exp_t e;
        logic [63:0] wm, fm, ax, bx, p;
        wm = (64'd1 << w) - 64'd1;
        fm = (w == 32) ? '1 : ((64'd1 << (2 * w)) - 64'd1);
        ax = {32'd0, x} & wm;
        bx = {32'd0, y} & wm;
        if (o == 3'd4 || o == 3'd5) begin
            if (ax[w-1]) ax = ax | ~wm;
            if (bx[w-1]) bx = bx | ~wm;
        end
        p = ax * bx;
        if (o == 3'd1) p = p + ({32'd0, l} & wm);
        if (o == 3'd3 || o == 3'd5)
            p = p + ((({32'd0, h} & wm) << w) | ({32'd0, l} & wm));
        p = p & fm;
        e = '0;
        if (o >= 3'd2 && o <= 3'd5) begin
            e.lo = 32'(p & wm);
            e.hi = 32'((p >> w) & wm);
            e.n  = p[2*w-1];
            e.z  = (p == 64'd0);
        end else if (o <= 3'd1) begin
            e.lo = 32'(p & wm);
            e.n  = p[w-1];
            e.z  = ((p & wm) == 64'd0);
        end else begin
            e.z = 1'b1;
        end
        return e;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        start0 = 1'b0;
        startc = 1'b0;
        op = '0; a = '0; b = '0; al = '0; ah = '0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({busy0, done0, lo0, hi0, n0, z0} !== 68'd0) begin
            miscompares++;
            $display("FAIL reset_u0 got b=%b d=%b lo=%h hi=%h n=%b z=%b want all 0",
                     busy0, done0, lo0, hi0, n0, z0);
        end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if ({c_busy[i], c_done[i], c_lo[i], c_hi[i], c_n[i], c_z[i]} !== 68'd0) begin
                miscompares++;
                $display("FAIL reset_cfg%0d got b=%b d=%b lo=%h hi=%h want all 0",
                         i, c_busy[i], c_done[i], c_lo[i], c_hi[i]);
            end
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int n;
        exp_t e;
        for (int v = 0; v < 5; v++) begin
            @(negedge clk);
            {op, a, b, al, ah} = VECS[v];
            start0 = 1'b1;
            sb.push_back(model(32, op, a, b, al, ah));
            @(posedge clk);
            #1;
            start0 = 1'b0;
            n = 0;
            while (done0 !== 1'b1 && n < 100) begin
                @(posedge clk);
                #1;
                n++;
            end
            vectors++;
            if (n !== 34) begin
                miscompares++;
                $display("FAIL basic%0d_latency got %0d want 34", v, n);
            end
            e = sb.pop_front();
            vectors++;
            if ({lo0, hi0, n0, z0} !== {e.lo, e.hi, e.n, e.z}) begin
                miscompares++;
                $display("FAIL basic%0d_result got lo=%h hi=%h n=%b z=%b want lo=%h hi=%h n=%b z=%b",
                         v, lo0, hi0, n0, z0, e.lo, e.hi, e.n, e.z);
            end
            @(posedge clk);
            #1;
            vectors++;
            if ({done0, busy0} !== 2'b00 || {lo0, hi0} !== {e.lo, e.hi}) begin
                miscompares++;
                $display("FAIL basic%0d_pulse got done=%b busy=%b lo=%h want done=0 busy=0 lo=%h",
                         v, done0, busy0, lo0, e.lo);
            end
        end
    endtask

    task automatic test_back_to_back();
        int n;
        exp_t e;
        @(negedge clk);
        op = 3'd0; a = 32'd3; b = 32'd4; al = '0; ah = '0;
        start0 = 1'b1;
        sb.push_back(model(32, op, a, b, al, ah));
        @(posedge clk);
        #1;
        start0 = 1'b0;
        n = 0;
        while (done0 !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 10) begin
                op = 3'd2; a = 32'd100; b = 32'd100;
                start0 = 1'b1;
            end
            if (n == 11) start0 = 1'b0;
        end
        vectors++;
        if (n !== 34) begin
            miscompares++;
            $display("FAIL ignore_latency got %0d want 34", n);
        end
        e = sb.pop_front();
        vectors++;
        if ({lo0, hi0, n0, z0} !== {e.lo, e.hi, e.n, e.z}) begin
            miscompares++;
            $display("FAIL ignore_result got lo=%h hi=%h want lo=%h hi=%h",
                     lo0, hi0, e.lo, e.hi);
        end
        op = 3'd3; a = 32'h1234_5678; b = 32'h9ABC_DEF0;
        al = 32'hDEAD_BEEF; ah = 32'h0000_0010;
        start0 = 1'b1;
        sb.push_back(model(32, op, a, b, al, ah));
        @(posedge clk);
        #1;
        start0 = 1'b0;
        vectors++;
        if ({busy0, done0} !== 2'b10) begin
            miscompares++;
            $display("FAIL b2b_accept got busy=%b done=%b want busy=1 done=0",
                     busy0, done0);
        end
        n = 0;
        while (done0 !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        vectors++;
        if (n !== 34) begin
            miscompares++;
            $display("FAIL b2b_latency got %0d want 34", n);
        end
        e = sb.pop_front();
        vectors++;
        if ({lo0, hi0, n0, z0} !== {e.lo, e.hi, e.n, e.z}) begin
            miscompares++;
            $display("FAIL b2b_result got lo=%h hi=%h n=%b z=%b want lo=%h hi=%h n=%b z=%b",
                     lo0, hi0, n0, z0, e.lo, e.hi, e.n, e.z);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        int seen;
        exp_t e;
        @(negedge clk);
        op = 3'd2; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; al = '0; ah = '0;
        start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        vectors++;
        if ({busy0, done0, lo0, hi0, n0, z0} !== 68'd0) begin
            miscompares++;
            $display("FAIL midreset_outputs got b=%b d=%b lo=%h hi=%h n=%b z=%b want all 0",
                     busy0, done0, lo0, hi0, n0, z0);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done0 === 1'b1 || busy0 === 1'b1) seen++;
        end
        vectors++;
        if (seen !== 0) begin
            miscompares++;
            $display("FAIL midreset_quiet got %0d active cycles want 0", seen);
        end
        @(negedge clk);
        op = 3'd0; a = 32'd5; b = 32'd5;
        start0 = 1'b1;
        sb.push_back(model(32, op, a, b, al, ah));
        @(posedge clk);
        #1;
        start0 = 1'b0;
        n = 0;
        while (done0 !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        vectors++;
        if (n !== 34) begin
            miscompares++;
            $display("FAIL postreset_latency got %0d want 34", n);
        end
        e = sb.pop_front();
        vectors++;
        if ({lo0, hi0, n0, z0} !== {e.lo, e.hi, e.n, e.z}) begin
            miscompares++;
            $display("FAIL postreset_result got lo=%h want lo=%h", lo0, e.lo);
        end
    endtask

    task automatic test_configs();
        int n;
        int lat [4];
        exp_t e;
        for (int v = 0; v < 6; v++) begin
            @(negedge clk);
            if (v < 5) {op, a, b, al, ah} = VECS[v];
            else begin
                op = 3'd6; a = 32'h1234; b = 32'h55; al = 32'h7; ah = 32'h9;
            end
            startc = 1'b1;
            for (int i = 0; i < 4; i++)
                sb.push_back(model(CWID[i], op, a, b, al, ah));
            @(posedge clk);
            #1;
            startc = 1'b0;
            lat = '{default: 0};
            n = 0;
            while (n < 60 && (lat[0] == 0 || lat[1] == 0 ||
                              lat[2] == 0 || lat[3] == 0)) begin
                @(posedge clk);
                #1;
                n++;
                for (int i = 0; i < 4; i++)
                    if (lat[i] == 0 && c_done[i] === 1'b1) lat[i] = n;
            end
            for (int i = 0; i < 4; i++) begin
                e = sb.pop_front();
                vectors++;
                if (lat[i] !== CLAT[i]) begin
                    miscompares++;
                    $display("FAIL cfg%0d_vec%0d_latency got %0d want %0d",
                             i, v, lat[i], CLAT[i]);
                end
                vectors++;
                if ({c_lo[i], c_hi[i], c_n[i], c_z[i]} !== {e.lo, e.hi, e.n, e.z}) begin
                    miscompares++;
                    $display("FAIL cfg%0d_vec%0d_result got lo=%h hi=%h n=%b z=%b want lo=%h hi=%h n=%b z=%b",
                             i, v, c_lo[i], c_hi[i], c_n[i], c_z[i],
                             e.lo, e.hi, e.n, e.z);
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_reset_mid();
        test_configs();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
